// File: rtl/sprite_pkg.sv
// ============================================================================
//  Module   : sprite_pkg
//  Purpose  : Shared types and constants for the sprite draw-and-animate
//             engine: the animation state enum, the active-screen size, and
//             a width helper that never returns zero.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } anim_state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Counter width for 0..v-1. Returns at least 1 so that v == 1 still
  // produces a legal vector width.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_anim_engine_if.sv
// ============================================================================
//  Module   : sprite_anim_engine_if
//  Purpose  : Sprite ROM bus between the engine and an external synchronous
//             ROM with a one-cycle read latency.
//  Ports    : rom_addr - ROM address driven by the engine (master)
//             rom_q    - ROM read data returned by the ROM (slave)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_anim_engine_if #(
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 4
);

  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;

  modport master (output rom_addr, input rom_q);
  modport slave  (input rom_addr, output rom_q);

endinterface

`default_nettype wire

// File: rtl/sprite_anim_ctrl.sv
// ============================================================================
//  Module   : sprite_anim_ctrl
//  Purpose  : Animation sequencer. Counts video-frame ticks, advances the
//             displayed animation frame every HOLD_TICKS ticks, loops or
//             stops on the last frame, and reports busy/done.
//  Ports    : vga_clk, reset   - pixel clock, synchronous active-high reset
//             frame_tick_i     - one pulse per video frame
//             start_i, loop_i  - (re)start animation; loop mode sampled on start
//             cur_frame_o      - frame currently displayed
//             busy_o           - high while playing (registered)
//             done_o           - one-cycle pulse when a one-shot finishes
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int FRAMES     = 6,
  parameter int HOLD_TICKS = 4,
  localparam int FRAME_W   = clog2_min1(FRAMES),
  localparam int HOLD_W    = clog2_min1(HOLD_TICKS)
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic               frame_tick_i,
  input  logic               start_i,
  input  logic               loop_i,
  output logic [FRAME_W-1:0] cur_frame_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);
  localparam logic [HOLD_W-1:0]  LAST_HOLD  = HOLD_W'(HOLD_TICKS - 1);

  anim_state_t        state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               loop_q, loop_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      frame_q <= '0;
      loop_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      loop_q  <= loop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    loop_d  = loop_q;

    // start overrides everything, including a coincident frame_tick, so
    // that tick is deliberately not counted.
    if (start_i) begin
      state_d = PLAY;
      hold_d  = '0;
      frame_d = '0;
      loop_d  = loop_i;
    end else begin
      case (state_q)
        IDLE: frame_d = '0;
        PLAY: begin
          if (frame_tick_i) begin
            if (hold_q == LAST_HOLD) begin
              hold_d = '0;
              if (frame_q == LAST_FRAME) begin
                if (loop_q) frame_d = '0;
                else        state_d = DONE;   // last frame stays on screen
              end else begin
                frame_d = frame_q + 1'b1;
              end
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end

    // Status flags are registered alongside the state, so they line up
    // with state_q rather than with the input pulse.
    busy_d = (state_d == PLAY);
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  assign cur_frame_o = frame_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

`default_nettype wire

// File: rtl/sprite_anim_engine.sv
// ============================================================================
//  Module   : sprite_anim_engine
//  Purpose  : Places one multi-frame sprite at a movable screen position,
//             addresses an external synchronous sprite ROM and produces a
//             per-pixel palette index with an opacity flag. Three-cycle
//             latency from DrawX/DrawY to pix_index/pix_opaque.
//  Config   : SPRITE_FLIP_EN - when defined, the latched facing bit mirrors
//             the sprite horizontally; otherwise facing is ignored.
//  Ports    : vga_clk, reset        - pixel clock, synchronous active-high reset
//             DrawX, DrawY, blank   - current pixel and active-video flag
//             frame_tick            - one pulse per video frame
//             pos_x, pos_y, facing  - requested placement (latched on tick)
//             start, loop           - animation control
//             rom                   - sprite ROM bus (master side)
//             pix_index, pix_opaque - pixel to the compositor
//             cur_frame, busy, done - animation status
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_anim_engine
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 74,
  parameter int SPR_H      = 103,
  parameter int FRAMES     = 6,
  parameter int HOLD_TICKS = 4,
  parameter int IDX_W      = 4,
  parameter int TRANSP_IDX = 0,
  parameter int ADDR_W     = $clog2(FRAMES * SPR_W * SPR_H),
  localparam int FRAME_W   = clog2_min1(FRAMES)
) (
  input  logic                 vga_clk,
  input  logic                 reset,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 blank,
  input  logic                 frame_tick,
  input  logic [9:0]           pos_x,
  input  logic [9:0]           pos_y,
  input  logic                 facing,
  input  logic                 start,
  input  logic                 loop,
  sprite_anim_engine_if.master rom,
  output logic [IDX_W-1:0]     pix_index,
  output logic                 pix_opaque,
  output logic [FRAME_W-1:0]   cur_frame,
  output logic                 busy,
  output logic                 done
);

  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(SPR_W * SPR_H);
  localparam logic [ADDR_W-1:0] ROW_PIX   = ADDR_W'(SPR_W);

  sprite_anim_ctrl #(
    .FRAMES     (FRAMES),
    .HOLD_TICKS (HOLD_TICKS)
  ) u_ctrl (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .frame_tick_i (frame_tick),
    .start_i      (start),
    .loop_i       (loop),
    .cur_frame_o  (cur_frame),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Shadow position, updated only at vsync so the box never tears mid-frame.
  logic [9:0] px_q, py_q;

  // 11-bit differences: a pixel left of / above the box shows up as bit 10
  // set instead of wrapping into a large in-range value.
  logic [10:0] lx, ly, lx_eff;
  logic        in_box;
  logic [ADDR_W-1:0] addr;

  assign lx = {1'b0, DrawX} - {1'b0, px_q};
  assign ly = {1'b0, DrawY} - {1'b0, py_q};

  assign in_box = !lx[10] && (lx[9:0] < 10'(SPR_W)) &&
                  !ly[10] && (ly[9:0] < 10'(SPR_H));

`ifdef SPRITE_FLIP_EN
  logic facing_q;

  always_ff @(posedge vga_clk) begin
    if (reset)           facing_q <= 1'b0;
    else if (frame_tick) facing_q <= facing;
  end

  assign lx_eff = facing_q ? (11'(SPR_W - 1) - lx) : lx;
`else
  logic unused_facing;
  assign unused_facing = facing;
  assign lx_eff        = lx;
`endif

  assign addr = ADDR_W'(cur_frame) * FRAME_PIX
              + ADDR_W'(ly) * ROW_PIX
              + ADDR_W'(lx_eff);

  logic [ADDR_W-1:0] rom_addr_q;
  logic              in_box1_q, blank1_q;   // aligned with rom_addr_q
  logic              in_box2_q, blank2_q;   // aligned with rom.rom_q
  logic [IDX_W-1:0]  pix_index_q;
  logic              pix_opaque_q;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      px_q         <= '0;
      py_q         <= '0;
      rom_addr_q   <= '0;
      in_box1_q    <= 1'b0;
      blank1_q     <= 1'b0;
      in_box2_q    <= 1'b0;
      blank2_q     <= 1'b0;
      pix_index_q  <= '0;
      pix_opaque_q <= 1'b0;
    end else begin
      if (frame_tick) begin
        px_q <= pos_x;
        py_q <= pos_y;
      end
      // Out-of-box pixels park the ROM address at 0.
      rom_addr_q <= in_box ? addr : '0;
      in_box1_q  <= in_box;
      blank1_q   <= blank;
      in_box2_q  <= in_box1_q;
      blank2_q   <= blank1_q;
      if (in_box2_q && blank2_q && (rom.rom_q != IDX_W'(TRANSP_IDX))) begin
        pix_index_q  <= rom.rom_q;
        pix_opaque_q <= 1'b1;
      end else begin
        pix_index_q  <= '0;
        pix_opaque_q <= 1'b0;
      end
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign pix_index    = pix_index_q;
  assign pix_opaque   = pix_opaque_q;

endmodule

`default_nettype wire

// File: doc/sprite_anim_engine.md
# sprite_anim_engine

Parametrised sprite draw-and-animate engine for the KOF-94 video path. It places one multi-frame sprite at a movable screen position and steps through animation frames once per video frame. It drives the address of an external synchronous sprite ROM and emits a per-pixel palette index plus an opacity flag to the layer compositor. It replaces the fixed, full-screen-stretched single-image sprite blocks.

## Interface
- SPR_W, 74: sprite width in pixels
- SPR_H, 103: sprite height in pixels
- FRAMES, 6: animation frames stored back-to-back in the ROM
- HOLD_TICKS, 4: video frames each animation frame is shown (≥1)
- IDX_W, 4: palette index width
- TRANSP_IDX, 0: palette index treated as transparent
- ADDR_W, $clog2(FRAMES*SPR_W*SPR_H): ROM address width (derived)
- vga_clk  in  1  pixel clock, all logic on posedge
- reset  in  1  synchronous, active-high
- DrawX, DrawY  in  10 each  current pixel coordinate
- blank  in  1  1 = active video
- frame_tick  in  1  one-cycle pulse per video frame (vsync start)
- pos_x, pos_y  in  10 each  sprite top-left requested position
- facing  in  1  1 = mirror horizontally (used only with flip enabled)
- start  in  1  one-cycle pulse: (re)start animation at frame 0
- loop  in  1  1 = loop animation, 0 = one-shot; sampled on start
- rom_addr  out  ADDR_W  address to sprite ROM (1-cycle synchronous read)
- rom_q  in  IDX_W  ROM data
- pix_index  out  IDX_W  palette index
- pix_opaque  out  1  1 = draw this sprite pixel
- cur_frame  out  $clog2(FRAMES)  frame being displayed
- busy  out  1  high in PLAY
- done  out  1  one-cycle pulse when a one-shot animation finishes

## Operation
- Shadow registers: pos_x, pos_y and facing are latched only on frame_tick, which prevents tearing. Reset value is 0.
- In-box test on the latched position, using 11-bit arithmetic so there is no wrap: lx = DrawX−px, ly = DrawY−py, valid when 0 ≤ lx < SPR_W and 0 ≤ ly < SPR_H. A sprite that is partly off the right or bottom edge is clipped.
- Address: rom_addr = cur_frame*SPR_W*SPR_H + ly*SPR_W + lx', where lx' = SPR_W−1−lx when flip is active, else lx.
- Out-of-box pixels, pixels with blank=0, or pixels with rom_q == TRANSP_IDX give pix_opaque=0 and pix_index=0.
- FSM states:
  - IDLE: show frame 0, no advancing.
  - PLAY: hold_cnt counts frame_ticks. At HOLD_TICKS−1 it resets and cur_frame advances. At the last frame: if loop, wrap to 0; else go to DONE.
  - DONE: hold the last frame. done pulses on the cycle DONE is entered. start returns to PLAY.
- start in any state: cur_frame=0, hold_cnt=0, go to PLAY, loop latched. If start and frame_tick coincide, start wins and that tick is not counted.
- cur_frame changes only on frame_tick or start, so it never changes mid-line except when start is pulsed. A restart mid-frame is allowed and takes effect on the next pixel.

## Timing
- Reset: the FSM is in IDLE, and cur_frame, hold_cnt, busy, done, pix_index, pix_opaque, rom_addr and the shadow registers are all 0.
- Pipeline, 3 cycles from DrawX/DrawY to outputs:
  - edge 1: rom_addr, in-box flag and blank registered
  - edge 2: ROM returns rom_q; flags delayed one stage
  - edge 3: pix_index and pix_opaque registered
- Downstream must delay sync signals by 3.
- busy is registered and follows the state with 1-cycle latency from start or the final tick.

## Configuration
- SPRITE_FLIP_EN:
  - Defined: the latched facing mirrors lx.
  - Undefined: the facing port exists but is ignored, lx' = lx, and the mirror logic is absent.

## Structure
- Shared package sprite_pkg: anim_state_t enum (IDLE, PLAY, DONE) and the screen constants H_ACTIVE=640, V_ACTIVE=480.
- One sub-module, sprite_anim_ctrl, holds the FSM, hold_cnt and cur_frame. The top level holds the shadow registers and the address/pixel pipeline.

## Test plan
- Reset, then no start: at pos (100,50), pixel (100,50) gives rom_addr=0 one cycle later. Pixel (173,152) gives addr 7621. Pixel (174,50) gives pix_opaque=0 three cycles later.
- start with loop=1, HOLD_TICKS=4: cur_frame steps 0→1 after the 4th tick, and wraps 5→0 after 24 ticks. done never pulses.
- start with loop=0: after 24 ticks the FSM is in DONE, done pulses exactly one cycle, and busy=0 with cur_frame held at 5.
- pos_x changed mid-frame: the box does not move until the next frame_tick. start and frame_tick in the same cycle give cur_frame=0 and hold_cnt=0.
- rom_q == TRANSP_IDX inside the box gives pix_opaque=0. blank=0 inside the box gives pix_opaque=0.
- With SPRITE_FLIP_EN and facing=1: pixel lx=0, ly=0 gives rom_addr=73. Without the macro it gives 0.
